seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter that produces the bit stream consumed by the 1011 sequence detector. It accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, followed by a configurable idle gap. It also keeps a registered reference model of the bits already sent and raises a Moore-aligned expected-detect flag. That flag lets a bench compare it cycle-for-cycle with the detector's zout.

Parameters:
WIDTH, 8, data bits per frame; must be >= 1.
GAP_BITS, 2, forced-0 bit times after each frame; 0 allowed.
PATTERN, 4'b1011, 4-bit pattern tracked by exp_z.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
din  input  WIDTH  frame data, bit WIDTH-1 sent first.
din_valid  input  1  din is valid.
din_ready  output  1  high only in IDLE; acceptance when din_valid && din_ready at a clk edge.
xout  output  1  serial data, registered; drives detector xin.
busy  output  1  high from the acceptance edge until IDLE is re-entered.
frame_done  output  1  one-cycle pulse in the first IDLE cycle after a completed frame.
exp_z  output  1  high while the last 4 sampled xout bits equal PATTERN.

Behaviour:
- Reset (rst high at an edge): state IDLE, xout=0, busy=0, frame_done=0, history=0, exp_z=0, bit counter=0. din_ready=1 from the first cycle after reset. Inputs are ignored while rst=1.
- States are IDLE, SHIFT, GAP.
- IDLE:
  - xout=0, din_ready=1.
  - On acceptance: latch din into the shift register, xout<=din[WIDTH-1], busy<=1, counter<=1, go to SHIFT.
- SHIFT:
  - Each edge presents the next bit on xout. Each data bit is held for exactly one cycle.
  - After the last bit's cycle: go to GAP if GAP_BITS>0, otherwise go to IDLE.
- GAP: xout=0 for exactly GAP_BITS cycles, then go to IDLE.
- Frame end:
  - On the edge entering IDLE from SHIFT or GAP: busy<=0, frame_done<=1 for one cycle.
  - Minimum one IDLE cycle between frames; no back-to-back acceptance.
- Frame length: busy is high for WIDTH+GAP_BITS cycles (plus 1 with parity).
- din_valid while busy: ignored. No latch, no effect on xout, din is not captured later unless din_valid is still high in IDLE.
- Reference model:
  - 4-bit history shifts in xout at every clk edge in all states: hist <= {hist[2:0], xout}.
  - exp_z = (hist == PATTERN), combinational from registered hist. Overlapping matches allowed.
  - Timing equals a Moore detector: exp_z rises in the cycle after the edge that sampled the final pattern bit.
  - hist continues shifting idle/gap zeros.
- Reset mid-frame: aborts immediately at the reset edge. xout=0, busy=0, no frame_done pulse, hist cleared, remaining bits discarded.
- Counter width: $clog2(WIDTH+GAP_BITS+2). No wrap within a frame.

Optional Feature:
TX_PARITY_EN
- Defined: one even-parity bit (XOR of all WIDTH data bits) is sent after the last data bit, before the gap. It is held one cycle and counted in busy. The reference model sees it like any other bit.
- Undefined: no parity bit; the frame is WIDTH data bits plus the gap, as above.

Test Plan:
All scenarios use WIDTH=8, GAP_BITS=2 unless noted.
1. Reset: rst=1 for 2 cycles, din_valid=1 -> xout=0, busy=0, frame_done=0, exp_z=0. After release din_ready=1, and no frame is started during reset.
2. Single frame din=8'b1011_0000, accepted at edge T0:
   - xout = 1,0,1,1,0,0,0,0 after edges T0..T7, then 0,0 (gap) after T8..T9.
   - exp_z high for exactly one cycle, after edge T4.
   - busy high for 10 cycles; frame_done single pulse after edge T10; din_ready=1 again after T10.
3. Overlap din=8'b1011_0110 -> bits 1,0,1,1,0,1,1,0 -> exp_z pulses twice, after edges T4 and T7; nothing else until IDLE.
4. Busy ignore: mid-frame, din_valid=1 with din=8'hFF for 3 cycles, then drop -> din_ready=0 throughout, xout sequence unchanged, no second frame starts.
5. Reset mid-frame: rst=1 for one edge after 3 bits of 8'b1111_1111 -> next cycle xout=0, busy=0, exp_z=0, no frame_done. A following din=8'b1011_0000 transmits correctly from bit 7.
6. With TX_PARITY_EN:
   - din=8'b1011_0001 -> 9th bit 0, busy 11 cycles.
   - din=8'b0000_0001 -> 9th bit 1.
   - Without the macro, the same inputs give an 8-bit frame and busy 10 cycles.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial frame transmitter with idle gap and a Moore-aligned pattern reference.
// Optional even parity bit after the data when TX_PARITY_EN is defined.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP_BITS = 2,
  parameter logic [3:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] din,
  input  logic din_valid,
  output logic din_ready,
  output logic xout,
  output logic busy,
  output logic frame_done,
  output logic exp_z
);
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CW = $clog2(WIDTH + GAP_BITS + 2);
  localparam logic [CW-1:0] W_C = CW'(WIDTH);
  localparam logic [CW-1:0] F_C = CW'(WIDTH + PAR);
  localparam logic [CW-1:0] G_C = CW'(GAP_BITS);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic [3:0] hist;
  logic par;
  assign din_ready = (state == IDLE);
  assign exp_z = (hist == PATTERN);
`ifdef TX_PARITY_EN
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (state == IDLE && din_valid) par <= ^din;
`else
  assign par = 1'b0;
`endif
  // cnt counts bit times already presented in SHIFT, then gap cycles in GAP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      xout <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      hist <= '0;
    end else begin
      hist <= {hist[2:0], xout};
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          xout <= 1'b0;
          if (din_valid) begin
            sr <= din << 1;
            xout <= din[WIDTH-1];
            busy <= 1'b1;
            cnt <= CW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt < W_C) begin
            xout <= sr[WIDTH-1];
            sr <= sr << 1;
            cnt <= cnt + CW'(1);
          end else if (cnt < F_C) begin
            xout <= par;
            cnt <= cnt + CW'(1);
          end else begin
            xout <= 1'b0;
            cnt <= CW'(1);
            if (GAP_BITS > 0) state <= GAP;
            else begin
              state <= IDLE;
              busy <= 1'b0;
              frame_done <= 1'b1;
            end
          end
        end
        GAP: begin
          xout <= 1'b0;
          if (cnt < G_C) cnt <= cnt + CW'(1);
          else begin
            state <= IDLE;
            busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed checks of seq_pattern_tx (WIDTH=8, GAP_BITS=2), parity-aware via TX_PARITY_EN.
module tb_seq_pattern_tx;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR + 2;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] din;
  logic din_valid;
  logic din_ready, xout, busy, frame_done, exp_z;
  int n_chk = 0;
  int n_ok = 0;
  seq_pattern_tx dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .xout(xout), .busy(busy), .frame_done(frame_done), .exp_z(exp_z)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input logic [7:0] d, input logic p, input logic [15:0] zmask, input logic noise);
    logic bit_exp;
    din = d;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = '0;
    for (int k = 0; k < NB; k++) begin
      bit_exp = (k < 8) ? d[7-k] : (k == 8 && PAR == 1) ? p : 1'b0;
      chk($sformatf("xout[%0h,T%0d]", d, k), xout, bit_exp);
      chk($sformatf("busy[%0h,T%0d]", d, k), busy, 1);
      chk($sformatf("ready[%0h,T%0d]", d, k), din_ready, 0);
      chk($sformatf("exp_z[%0h,T%0d]", d, k), exp_z, zmask[k]);
      chk($sformatf("done[%0h,T%0d]", d, k), frame_done, 0);
      if (noise) begin
        din_valid = (k >= 1 && k <= 3);
        din = 8'hFF;
      end
      step();
    end
    din_valid = 1'b0;
    chk("end_busy", busy, 0);
    chk("end_done", frame_done, 1);
    chk("end_ready", din_ready, 1);
    chk("end_exp_z", exp_z, zmask[NB]);
    chk("end_xout", xout, 0);
    step();
    chk("post_done", frame_done, 0);
    chk("post_busy", busy, 0);
  endtask
  initial begin
    rst = 1'b1;
    din_valid = 1'b1;
    din = 8'hB0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_xout", xout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_exp_z", exp_z, 0);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    step();
    chk("rel_ready", din_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_xout", xout, 0);
    run_frame(8'b1011_0000, 1'b1, 16'h0010, 1'b0);
    step();
    run_frame(8'b1011_0110, 1'b1, 16'h0090, 1'b0);
    step();
    run_frame(8'b1100_1010, 1'b0, 16'h0000, 1'b1);
    step();
    chk("noise_no_frame", busy, 0);
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    chk("mid_xout", xout, 1);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_xout", xout, 0);
    chk("abort_busy", busy, 0);
    chk("abort_exp_z", exp_z, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_ready", din_ready, 1);
    step();
    chk("abort_done2", frame_done, 0);
    chk("abort_busy2", busy, 0);
    run_frame(8'b1011_0000, 1'b1, 16'h0010, 1'b0);
    step();
    run_frame(8'b1011_0001, 1'b0, 16'h0010, 1'b0);
    step();
    run_frame(8'b0000_0001, 1'b1, 16'h0000, 1'b0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
